// File: rtl/node_chk_pkg.sv
// rtl/node_chk_pkg.sv - shared constants and state encoding for the node trace checker
package node_chk_pkg;

  // Register offsets inside the CPU result window
  localparam logic [31:0] OFF_START = 32'h0000_0000;
  localparam logic [31:0] OFF_END   = 32'h0000_0004;
  localparam logic [31:0] OFF_NODE  = 32'h0000_0008;
  localparam logic [31:0] OFF_DONE  = 32'h0000_000C;

  // Only this exact value written to DONE finishes a run
  localparam int unsigned DONE_MAGIC = 1;

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/exp_seq_buf.sv
// rtl/exp_seq_buf.sv - expected node sequence storage with fill counter and full flag
module exp_seq_buf #(
  parameter  int NODE_W = 5,
  parameter  int DEPTH  = 16,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int CNT_W  = IDX_W + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,   // asynchronous, active-low
  input  logic              i_push,
  input  logic              i_clear,
  input  logic [NODE_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [NODE_W-1:0] o_rdata,
  output logic [CNT_W-1:0]  o_loaded,
  output logic              o_full
);

  logic [NODE_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_loaded;
  logic              r_full;
  logic              w_room;

  assign w_room = (r_loaded != CNT_W'(DEPTH));

  // Storage is deliberately not reset; only the fill pointer defines valid entries
  always_ff @(posedge i_clk) begin
    if (i_push && w_room && !i_clear) begin
      r_mem[r_loaded[IDX_W-1:0]] <= i_wdata;
    end
  end

  // Fill counter advances on accepted pushes; a push with no room sets the sticky full flag
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_loaded <= '0;
      r_full   <= 1'b0;
    end else if (i_clear) begin
      r_loaded <= '0;
      r_full   <= 1'b0;
    end else if (i_push) begin
      if (w_room) begin
        r_loaded <= r_loaded + 1'b1;
      end else begin
        r_full <= 1'b1;
      end
    end
  end

  assign o_rdata  = r_mem[i_raddr];
  assign o_loaded = r_loaded;
  assign o_full   = r_full;

endmodule

// File: rtl/node_trace_checker.sv
// rtl/node_trace_checker.sv - snoops CPU result-window writes and checks the node sequence
module node_trace_checker
  import node_chk_pkg::*;
#(
  parameter  int                DATA_W     = 32,
  parameter  int                ADDR_W     = 32,
  parameter  int                NODE_W     = 5,
  parameter  int                DEPTH      = 16,
  parameter  logic [ADDR_W-1:0] BASE_ADDR  = 32'h0200_0000,
  parameter  int                ERR_W      = 8,
  parameter  bit                STRICT_LEN = 1'b1,
  localparam int                IDX_W      = $clog2(DEPTH),
  localparam int                CNT_W      = IDX_W + 1
) (
  input  logic              i_clk,
  input  logic              i_reset,   // asynchronous, active-low
  input  logic              i_exp_wr_en,
  input  logic [NODE_W-1:0] i_exp_wr_data,
  input  logic              i_exp_clear,
  input  logic              i_arm,
  input  logic              i_bus_we,
  input  logic [ADDR_W-1:0] i_bus_addr,
  input  logic [DATA_W-1:0] i_bus_wdata,
  output logic [NODE_W-1:0] o_start_pt,
  output logic [NODE_W-1:0] o_end_pt,
  output logic [CNT_W-1:0]  o_loaded,
  output logic [CNT_W-1:0]  o_checked,
  output logic [ERR_W-1:0]  o_err_count,
  output logic [CNT_W-1:0]  o_first_err_idx,
  output logic              o_load_full,
  output logic              o_running,
  output logic              o_done,
  output logic              o_pass
);

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_e            r_state, w_next;
  logic [CNT_W-1:0]  r_checked, r_first;
  logic [ERR_W-1:0]  r_err;
  logic [NODE_W-1:0] r_start, r_end;

  logic [NODE_W-1:0] w_exp_node;
  logic [CNT_W-1:0]  w_loaded;
  logic              w_full;
  logic              w_idle, w_in_run, w_clear, w_push, w_arm_go;
  logic              w_hit_start, w_hit_end, w_hit_node, w_done_wr;
  logic              w_has_exp, w_node_err, w_under, w_err_ev;

  assign w_idle   = (r_state == S_LOAD) || (r_state == S_DONE);
  assign w_in_run = (r_state == S_RUN) && i_bus_we;
  assign w_clear  = i_exp_clear && w_idle;
  assign w_push   = i_exp_wr_en && (r_state == S_LOAD);
  assign w_arm_go = i_arm && w_idle && !w_clear;

  assign w_hit_start = w_in_run && (i_bus_addr == BASE_ADDR + ADDR_W'(OFF_START));
  assign w_hit_end   = w_in_run && (i_bus_addr == BASE_ADDR + ADDR_W'(OFF_END));
  assign w_hit_node  = w_in_run && (i_bus_addr == BASE_ADDR + ADDR_W'(OFF_NODE));
  assign w_done_wr   = w_in_run && (i_bus_addr == BASE_ADDR + ADDR_W'(OFF_DONE))
                       && (i_bus_wdata == DATA_W'(DONE_MAGIC));

  // Writes beyond the loaded length are errors without a compare; finishing short is one error
  assign w_has_exp  = (r_checked < w_loaded);
  assign w_node_err = w_hit_node && (!w_has_exp || (w_exp_node != i_bus_wdata[NODE_W-1:0]));
  assign w_under    = w_done_wr && STRICT_LEN && w_has_exp;
  assign w_err_ev   = w_node_err || w_under;

  exp_seq_buf #(
    .NODE_W (NODE_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_push   (w_push),
    .i_clear  (w_clear),
    .i_wdata  (i_exp_wr_data),
    .i_raddr  (r_checked[IDX_W-1:0]),
    .o_rdata  (w_exp_node),
    .o_loaded (w_loaded),
    .o_full   (w_full)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_LOAD;
    else          r_state <= w_next;
  end

  // Next-state: clear beats arm from the idle states; only the DONE magic ends a run
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  if (w_arm_go) w_next = S_RUN;
      S_RUN:   if (w_done_wr) w_next = S_DONE;
      S_DONE: begin
        if (w_clear)       w_next = S_LOAD;
        else if (w_arm_go) w_next = S_RUN;
      end
      default: w_next = S_LOAD;
    endcase
  end

  // Run counters and captured points; cleared on every arm so a re-run starts fresh
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_checked <= '0;
      r_err     <= '0;
      r_first   <= '0;
      r_start   <= '0;
      r_end     <= '0;
    end else if (w_arm_go) begin
      r_checked <= '0;
      r_err     <= '0;
      r_first   <= '0;
      r_start   <= '0;
      r_end     <= '0;
    end else begin
      if (w_hit_node && (r_checked != CNT_W'(DEPTH))) r_checked <= r_checked + 1'b1;
      if (w_err_ev) begin
        if (r_err == '0)     r_first <= r_checked;
        if (r_err != ERR_MAX) r_err  <= r_err + 1'b1;
      end
      if (w_hit_start) r_start <= i_bus_wdata[NODE_W-1:0];
      if (w_hit_end)   r_end   <= i_bus_wdata[NODE_W-1:0];
    end
  end

  // State flags; pass is derived from the final counters, which already hold any underflow error
  always_comb begin
    o_running = (r_state == S_RUN);
    o_done    = (r_state == S_DONE);
    o_pass    = (r_state == S_DONE) && (r_err == '0) && (r_checked != '0);
  end

  assign o_start_pt      = r_start;
  assign o_end_pt        = r_end;
  assign o_loaded        = w_loaded;
  assign o_checked       = r_checked;
  assign o_err_count     = r_err;
  assign o_first_err_idx = r_first;
  assign o_load_full     = w_full;

endmodule

// File: doc/node_trace_checker.md
# node_trace_checker

Synthesizable bus-snooping checker for the path-finding CPU's memory-mapped result window, and the parametrised successor of the simulation-only node-point check. It is preloaded with an expected node sequence of up to DEPTH entries, then watches CPU data writes to the START, END, NODE and DONE registers. It compares each NODE write in order, counts mismatches and length violations, and reports pass/fail when the CPU writes DONE=1. It sits beside the CPU data port, in parallel with data memory, and never drives the bus.

## Interface
- DATA_W, 32, bus write-data width
- ADDR_W, 32, bus address width
- NODE_W, 5, compared node-id width; the low NODE_W bits of write data are used
- DEPTH, 16, expected-sequence capacity; power of two, ≥2
- BASE_ADDR, 32'h0200_0000, window base; START=+0x0, END=+0x4, NODE=+0x8, DONE=+0xC
- ERR_W, 8, error-counter width; the counter saturates
- STRICT_LEN, 1, when 1, PASS also requires checked count == loaded count

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- exp_wr_en  in  1  push exp_wr_data into the expected buffer; honoured in LOAD only
- exp_wr_data  in  NODE_W  expected node id
- exp_clear  in  1  empty the buffer and return to LOAD; honoured in LOAD or DONE
- arm  in  1  LOAD/DONE→RUN
- bus_we  in  1  CPU data-write strobe
- bus_addr  in  ADDR_W  CPU data address
- bus_wdata  in  DATA_W  CPU write data
- start_pt, end_pt  out  NODE_W  last values written to START/END in RUN
- loaded  out  $clog2(DEPTH)+1  entries in buffer
- checked  out  $clog2(DEPTH)+1  NODE writes compared
- err_count  out  ERR_W  saturating error count
- first_err_idx  out  $clog2(DEPTH)+1  index of the first error; valid when err_count≠0
- load_full  out  1  sticky; a push was dropped because the buffer was full
- running, done, pass  out  1  state flags; pass is meaningful only when done=1

## Operation
- FSM states: LOAD (reset state), RUN, DONE.
- **LOAD**
  - exp_wr_en writes mem[loaded] and increments loaded.
  - When loaded==DEPTH, pushes are dropped and load_full is set.
  - arm → RUN; on entry, checked, err_count, first_err_idx, start_pt and end_pt are cleared.
- **RUN**, per cycle with bus_we=1:
  - START: capture start_pt.
  - END: capture end_pt.
  - NODE:
    - If checked<loaded: compare bus_wdata[NODE_W-1:0] with mem[checked]. A mismatch is an error.
    - If checked≥loaded: overflow error, no compare.
    - checked increments in both cases, saturating at DEPTH.
  - DONE with bus_wdata==1: go to DONE. Any other DONE value is ignored.
  - Other addresses are ignored. exp_wr_en and exp_clear are ignored in RUN.
- **Errors**: err_count increments and saturates at 2^ERR_W−1. first_err_idx latches the value of checked at the first error only.
- **Finish**: on DONE entry, if STRICT_LEN and checked<loaded, one underflow error is added in the same cycle.
- **pass** = (err_count==0) && (checked≠0), computed from the final values that include the underflow error.
- **DONE**:
  - Outputs hold.
  - arm re-runs the same expected sequence.
  - exp_clear sets loaded=0, clears load_full, and goes to LOAD.
  - If arm and exp_clear are asserted together, exp_clear wins.
- The mem contents are not reset. Only the pointers and counters are.

## Timing
- Reset values: state=LOAD, every count = 0, all flags = 0, start_pt = end_pt = 0.
- Reset asserted mid-RUN aborts immediately to LOAD with the buffer emptied.
- Snooped write at edge N:
  - checked, err_count and first_err_idx update at edge N.
  - The new values are visible after N, i.e. 1-cycle latency.
- DONE write at edge N: done=1, running=0 and pass are valid after N, including any underflow error.
- arm at edge N: running=1 after N. A NODE write in the same cycle as arm is not checked.
- Back-to-back NODE writes on consecutive cycles are all checked. There are no stall or ready signals.

## Structure
- Package node_chk_pkg holds:
  - register offsets OFF_START, OFF_END, OFF_NODE, OFF_DONE;
  - the DONE_MAGIC value (1);
  - the state enum {S_LOAD, S_RUN, S_DONE}.
- Sub-module exp_seq_buf: DEPTH×NODE_W storage with a synchronous write port and an asynchronous read at the checked index, plus a loaded counter and a full flag.
- FSM, address decode and counters live in the top module.

## Test plan
- **Pass case**: load 3,7,12,9; arm; NODE writes 3,7,12,9; DONE=1 → done=1, pass=1, err_count=0, checked=4.
- **Mismatch**: same load; NODE writes 3,8,12,1 → err_count=2, first_err_idx=1, pass=0.
- **Length violations**:
  - 2 loaded, 3 NODE writes → err_count=1 (overflow), first_err_idx=2.
  - 4 loaded, 2 correct writes, STRICT_LEN=1 → err_count=1 after DONE, pass=0.
- **Full buffer, empty run, capture**:
  - 17 pushes with DEPTH=16 → loaded=16, load_full=1.
  - Arm with 0 loaded, DONE=1 → pass=0.
  - START=0x4 write → start_pt=4.
- **Boundaries**:
  - Reset pulse mid-RUN → all outputs return to reset values at once.
  - DONE write of 2 → ignored.
  - Re-arm from DONE → counters cleared and same sequence passes again.
  - err_count at 8 bits saturates at 255 under 300 bad writes (DEPTH=512).
